// File: rtl/etc_id_encoder_if.sv
// Pixel-in / block-out bundle for the ETC1 individual-mode encoder.
//   pix_rtr   : pixel valid (source -> encoder)
//   pix_rdy   : encoder accepting pixels
//   flip      : subblock orientation, taken with pixel 0
//   r, g, b   : pixel colour
//   block_rts : one-cycle pulse, block valid
//   block     : packed 64-bit ETC1 block, held until the next pulse
//   busy      : encoder is not in its pixel-load state
// The master modport is the pixel source / block sink; slave is the encoder.
interface etc_id_encoder_if;
  logic        pix_rtr;
  logic        pix_rdy;
  logic        flip;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        block_rts;
  logic [63:0] block;
  logic        busy;

  modport master (
    output pix_rtr, flip, r, g, b,
    input  pix_rdy, block_rts, block, busy
  );

  modport slave (
    input  pix_rtr, flip, r, g, b,
    output pix_rdy, block_rts, block, busy
  );
endinterface

// File: rtl/etc_id_encoder.sv
// ETC1 individual-mode block encoder.
// Loads a 4x4 RGB888 tile (pixel index i = x*4 + y), derives a 4-bit base colour per subblock,
// picks a modifier table per subblock and per-pixel indices, then emits the 64-bit block.
// Ports:
//   sclk : clock
//   rsrt : asynchronous active-high reset
//   bus  : etc_id_encoder_if.slave (pixel handshake in, block pulse out, busy)
// Build option: ETC_ENC_TABLE_SEARCH_EN defined adds the 8-table SEARCH state; otherwise
// both subblocks use table 3 and BASE goes straight to INDEX.
module etc_id_encoder (
  input  logic             sclk,
  input  logic             rsrt,
  etc_id_encoder_if.slave  bus
);

  typedef enum logic [2:0] {StLoad, StBase, StSearch, StIndex, StPack} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  flip_q, flip_d;
  logic [15:0][23:0]     pix_q, pix_d;     // {r, g, b} per pixel index
  logic [1:0][2:0][10:0] sum_q, sum_d;     // [subblock][channel], channel 2 = R
  logic [1:0][11:0]      base_q, base_d;   // 4-bit {R, G, B} per subblock
  logic [15:0]           msb_q, msb_d;
  logic [15:0]           lsb_q, lsb_d;
  logic [63:0]           block_q, block_d;
  logic                  block_rts_q, block_rts_d;

  logic [1:0][2:0]       sel_tbl;
  logic                  sb;
  logic                  sb_load;
  logic [23:0]           pix_cur;
  logic [2:0]            tbl_cur;
  logic [11:0]           bc;               // {error, code} of best code for pix_cur

`ifdef ETC_ENC_TABLE_SEARCH_EN
  logic [2:0]            tbl_q, tbl_d;
  logic [1:0][12:0]      acc_q, acc_d;
  logic [1:0][12:0]      best_err_q, best_err_d;
  logic [1:0][2:0]       best_tbl_q, best_tbl_d;
  assign sel_tbl = best_tbl_q;
`else
  logic                  unused_err;
  assign sel_tbl    = {3'd3, 3'd3};
  assign unused_err = ^bc[11:2];
`endif

  // Rounded 3-bit-shift average, then round to 4 bits with saturation.
  function automatic logic [3:0] quant(input logic [10:0] sum);
    logic [11:0] avg;
    logic [11:0] rnd;
    avg = ({1'b0, sum} + 12'd4) >> 3;
    rnd = (avg + 12'd8) >> 4;
    return (rnd > 12'd15) ? 4'd15 : rnd[3:0];
  endfunction

  // {a, b} modifier magnitudes.
  function automatic logic [15:0] mod_pair(input logic [2:0] t);
    logic [15:0] ab;
    case (t)
      3'd0:    ab = {8'd2,  8'd8};
      3'd1:    ab = {8'd5,  8'd17};
      3'd2:    ab = {8'd9,  8'd29};
      3'd3:    ab = {8'd13, 8'd42};
      3'd4:    ab = {8'd18, 8'd60};
      3'd5:    ab = {8'd24, 8'd80};
      3'd6:    ab = {8'd33, 8'd106};
      default: ab = {8'd47, 8'd183};
    endcase
    return ab;
  endfunction

  // Lowest-error code for one pixel; codes scanned 0..3 with strict compare so ties keep
  // the lower code.
  function automatic logic [11:0] best_code(input logic [23:0] pix, input logic [11:0] base,
                                            input logic [2:0] t);
    logic [15:0] ab;
    logic [7:0]  m;
    logic [7:0]  p;
    logic [7:0]  bexp;
    logic [8:0]  c_val;
    logic [9:0]  e;
    logic [9:0]  best_e;
    logic [1:0]  best_c;
    ab     = mod_pair(t);
    best_e = '1;
    best_c = 2'd0;
    for (int code = 0; code < 4; code++) begin
      m = code[0] ? ab[7:0] : ab[15:8];
      e = '0;
      for (int ch = 0; ch < 3; ch++) begin
        p    = pix[ch*8 +: 8];
        bexp = {base[ch*4 +: 4], base[ch*4 +: 4]};
        if (code[1]) begin
          c_val = (bexp > m) ? {1'b0, bexp - m} : 9'd0;
        end else begin
          c_val = (({1'b0, bexp} + {1'b0, m}) > 9'd255) ? 9'd255 : ({1'b0, bexp} + {1'b0, m});
        end
        e = e + ((c_val > {1'b0, p}) ? {1'b0, c_val - {1'b0, p}} : {1'b0, {1'b0, p} - c_val});
      end
      if (e < best_e) begin
        best_e = e;
        best_c = 2'(code);
      end
    end
    return {best_e, best_c};
  endfunction

  // flip for pixel 0 comes straight from the bus since it is sampled in the same cycle.
  assign sb_load = ((cnt_q == 4'd0) ? bus.flip : flip_q) ? cnt_q[1] : cnt_q[3];
  assign sb      = flip_q ? cnt_q[1] : cnt_q[3];
  assign pix_cur = pix_q[cnt_q];
`ifdef ETC_ENC_TABLE_SEARCH_EN
  assign tbl_cur = (state_q == StSearch) ? tbl_q : sel_tbl[sb];
`else
  assign tbl_cur = sel_tbl[sb];
`endif
  assign bc      = best_code(pix_cur, base_q[sb], tbl_cur);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flip_d      = flip_q;
    pix_d       = pix_q;
    sum_d       = sum_q;
    base_d      = base_q;
    msb_d       = msb_q;
    lsb_d       = lsb_q;
    block_d     = block_q;
    block_rts_d = 1'b0;
`ifdef ETC_ENC_TABLE_SEARCH_EN
    tbl_d       = tbl_q;
    acc_d       = acc_q;
    best_err_d  = best_err_q;
    best_tbl_d  = best_tbl_q;
`endif
    case (state_q)
      StLoad: begin
        if (bus.pix_rtr) begin
          if (cnt_q == 4'd0) flip_d = bus.flip;
          pix_d[cnt_q]       = {bus.r, bus.g, bus.b};
          sum_d[sb_load][2]  = sum_q[sb_load][2] + {3'b0, bus.r};
          sum_d[sb_load][1]  = sum_q[sb_load][1] + {3'b0, bus.g};
          sum_d[sb_load][0]  = sum_q[sb_load][0] + {3'b0, bus.b};
          cnt_d              = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = StBase;
        end
      end
      StBase: begin
        for (int s = 0; s < 2; s++) begin
          for (int ch = 0; ch < 3; ch++) begin
            base_d[s][ch*4 +: 4] = quant(sum_q[s][ch]);
          end
        end
        sum_d = '0;  // ready for the next tile
`ifdef ETC_ENC_TABLE_SEARCH_EN
        state_d = StSearch;
`else
        state_d = StIndex;
`endif
      end
`ifdef ETC_ENC_TABLE_SEARCH_EN
      StSearch: begin
        acc_d[sb] = acc_q[sb] + {3'b0, bc[11:2]};
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          // Table 0 always seeds the best; later tables need a strictly smaller total.
          for (int s = 0; s < 2; s++) begin
            if ((tbl_q == 3'd0) || (acc_d[s] < best_err_q[s])) begin
              best_err_d[s] = acc_d[s];
              best_tbl_d[s] = tbl_q;
            end
          end
          acc_d = '0;
          tbl_d = tbl_q + 3'd1;
          if (tbl_q == 3'd7) state_d = StIndex;
        end
      end
`endif
      StIndex: begin
        msb_d[cnt_q] = bc[1];
        lsb_d[cnt_q] = bc[0];
        cnt_d        = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = StPack;
      end
      StPack: begin
        block_d = {base_q[0][11:8], base_q[1][11:8],
                   base_q[0][7:4],  base_q[1][7:4],
                   base_q[0][3:0],  base_q[1][3:0],
                   sel_tbl[0], sel_tbl[1], 1'b0, flip_q,
                   msb_q, lsb_q};
        block_rts_d = 1'b1;
        state_d     = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge sclk or posedge rsrt) begin
    if (rsrt) begin
      state_q     <= StLoad;
      cnt_q       <= '0;
      flip_q      <= 1'b0;
      pix_q       <= '0;
      sum_q       <= '0;
      base_q      <= '0;
      msb_q       <= '0;
      lsb_q       <= '0;
      block_q     <= '0;
      block_rts_q <= 1'b0;
`ifdef ETC_ENC_TABLE_SEARCH_EN
      tbl_q       <= '0;
      acc_q       <= '0;
      best_err_q  <= '0;
      best_tbl_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flip_q      <= flip_d;
      pix_q       <= pix_d;
      sum_q       <= sum_d;
      base_q      <= base_d;
      msb_q       <= msb_d;
      lsb_q       <= lsb_d;
      block_q     <= block_d;
      block_rts_q <= block_rts_d;
`ifdef ETC_ENC_TABLE_SEARCH_EN
      tbl_q       <= tbl_d;
      acc_q       <= acc_d;
      best_err_q  <= best_err_d;
      best_tbl_q  <= best_tbl_d;
`endif
    end
  end

  assign bus.pix_rdy   = (state_q == StLoad);
  assign bus.busy      = (state_q != StLoad);
  assign bus.block     = block_q;
  assign bus.block_rts = block_rts_q;

endmodule

// File: tb/tb_etc_id_encoder.sv
`timescale 1ns/1ps
module tb_etc_id_encoder;

  logic sclk = 1'b0;
  logic rsrt;

  etc_id_encoder_if bus ();

  etc_id_encoder dut (
    .sclk (sclk),
    .rsrt (rsrt),
    .bus  (bus)
  );

  always #5 sclk = ~sclk;

`ifdef ETC_ENC_TABLE_SEARCH_EN
  localparam bit          Search   = 1'b1;
  localparam int          Lat      = 146;
  localparam int          ResetAt  = 51;
  localparam logic [63:0] GreyBlk  = 64'h88888800FFFFFFFF;
  localparam logic [63:0] White0   = 64'hFFFFFF0000000000;
  localparam logic [63:0] White1   = 64'hFFFFFF0100000000;
  localparam logic [63:0] SplitBlk = 64'h0F0F0F0000FF0000;
`else
  localparam bit          Search   = 1'b0;
  localparam int          Lat      = 18;
  localparam int          ResetAt  = 8;
  localparam logic [63:0] GreyBlk  = 64'h8888886CFFFF0000;
  localparam logic [63:0] White0   = 64'hFFFFFF6C00000000;
  localparam logic [63:0] White1   = 64'hFFFFFF6D00000000;
  localparam logic [63:0] SplitBlk = 64'h0F0F0F6C00FF0000;
`endif
  // Pixel 0 of a back-to-back tile is taken on the edge right after the previous pulse.
  localparam int Period = Lat + 16;

  typedef struct {
    logic [63:0] blk;
    int          e0;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   mon_acc  = 0;
  int   drv_acc  = 0;
  int   pulse_last = -1;
  int   pulse_prev = -1;
  logic prev_rts = 1'b0;

  int tab_a [8] = '{2, 5, 9, 13, 18, 24, 33, 47};
  int tab_b [8] = '{8, 17, 29, 42, 60, 80, 106, 183};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int sb_of(input int i, input bit fl);
    return fl ? ((i >> 1) & 1) : ((i >= 8) ? 1 : 0);
  endfunction

  function automatic int chv(input logic [23:0] p, input int ch);  // ch 0 = R
    return int'(p[23 - 8*ch -: 8]);
  endfunction

  function automatic int pix_err(input logic [23:0] p, input int q0, input int q1, input int q2,
                                 input int t, input int code);
    int qa [3];
    int mod, c, d, e;
    qa  = '{q0, q1, q2};
    mod = (code % 2 == 1) ? tab_b[t] : tab_a[t];
    if (code >= 2) mod = -mod;
    e = 0;
    for (int ch = 0; ch < 3; ch++) begin
      c = qa[ch] * 17 + mod;
      if (c < 0)   c = 0;
      if (c > 255) c = 255;
      d = chv(p, ch) - c;
      e += (d < 0) ? -d : d;
    end
    return e;
  endfunction

  function automatic void pick(input logic [23:0] p, input int q0, input int q1, input int q2,
                               input int t, output int code, output int err);
    int e;
    err  = 1 << 30;
    code = 0;
    for (int c = 0; c < 4; c++) begin
      e = pix_err(p, q0, q1, q2, t, c);
      if (e < err) begin
        err  = e;
        code = c;
      end
    end
  endfunction

  function automatic logic [63:0] model_block(input logic [23:0] px [16], input bit fl);
    int sum [2][3];
    int q [2][3];
    int tbl [2];
    int best, tot, code, err, s;
    logic [15:0] msb, lsb;
    for (int k = 0; k < 2; k++) for (int ch = 0; ch < 3; ch++) sum[k][ch] = 0;
    for (int i = 0; i < 16; i++)
      for (int ch = 0; ch < 3; ch++) sum[sb_of(i, fl)][ch] += chv(px[i], ch);
    for (int k = 0; k < 2; k++)
      for (int ch = 0; ch < 3; ch++) begin
        q[k][ch] = ((sum[k][ch] + 4) / 8 + 8) / 16;
        if (q[k][ch] > 15) q[k][ch] = 15;
      end
    for (int k = 0; k < 2; k++) begin
      tbl[k] = 3;
      if (Search) begin
        best = 1 << 30;
        for (int t = 0; t < 8; t++) begin
          tot = 0;
          for (int i = 0; i < 16; i++)
            if (sb_of(i, fl) == k) begin
              pick(px[i], q[k][0], q[k][1], q[k][2], t, code, err);
              tot += err;
            end
          if (tot < best) begin
            best   = tot;
            tbl[k] = t;
          end
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      s = sb_of(i, fl);
      pick(px[i], q[s][0], q[s][1], q[s][2], tbl[s], code, err);
      msb[i] = code[1];
      lsb[i] = code[0];
    end
    return {4'(q[0][0]), 4'(q[1][0]), 4'(q[0][1]), 4'(q[1][1]), 4'(q[0][2]), 4'(q[1][2]),
            3'(tbl[0]), 3'(tbl[1]), 1'b0, fl, msb, lsb};
  endfunction

  // ---------------- monitors ----------------
  always @(posedge sclk) begin
    cyc++;
    if (!rsrt && bus.pix_rtr && bus.pix_rdy) mon_acc++;
  end

  always @(negedge sclk) begin
    if (!rsrt) begin
      if (prev_rts) check("pulse_width", 64'(bus.block_rts), 64'd0);
      if (bus.block_rts && !prev_rts) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", 64'(bus.block_rts), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("block", bus.block, e.blk);
          check("latency", 64'(cyc - e.e0), 64'(Lat));
          check("rdy_at_pulse", 64'(bus.pix_rdy), 64'd1);
          check("busy_at_pulse", 64'(bus.busy), 64'd0);
        end
        pulse_prev = pulse_last;
        pulse_last = cyc;
      end
      prev_rts = bus.block_rts;
    end else begin
      prev_rts = 1'b0;
    end
  end

  // ---------------- driver ----------------
  task automatic send_tile(input logic [23:0] px [16], input bit fl, input bit gaps,
                           input bit push, input logic [63:0] exp_blk);
    for (int i = 0; i < 16; i++) begin
      bit   done;
      int   guard;
      int   idle;
      logic rd;
      done  = 1'b0;
      guard = 0;
      idle  = 0;
      if (gaps && ($urandom_range(0, 2) == 0)) idle = $urandom_range(1, 3);
      repeat (idle) begin
        bus.pix_rtr = 1'b0;
        {bus.r, bus.g, bus.b} = 24'($urandom);
        bus.flip = 1'($urandom);
        @(negedge sclk);
      end
      bus.pix_rtr = 1'b1;
      {bus.r, bus.g, bus.b} = px[i];
      bus.flip = (i == 0) ? fl : 1'($urandom);
      while (!done) begin
        rd = bus.pix_rdy;
        @(negedge sclk);
        if (rd) begin
          done = 1'b1;
        end else begin
          guard++;
          if (guard > 400) begin
            $display("FAIL accept_timeout: pixel %0d not accepted, required within 400 cycles", i);
            $fatal(1);
          end
        end
      end
      drv_acc++;
    end
    if (push) sb_q.push_back('{exp_blk, cyc});
    // Keep offering junk while the encoder is busy; none of it may be taken.
    bus.pix_rtr = 1'b1;
    {bus.r, bus.g, bus.b} = 24'($urandom);
  endtask

  task automatic wait_pulse();
    int guard;
    guard = 0;
    while (!bus.block_rts) begin
      @(negedge sclk);
      guard++;
      if (guard > 400) begin
        $display("FAIL pulse_timeout: no block_rts, required within 400 cycles");
        $fatal(1);
      end
    end
    bus.pix_rtr = 1'b0;
  endtask

  task automatic fill(output logic [23:0] px [16], input logic [23:0] lo, input logic [23:0] hi);
    for (int i = 0; i < 16; i++) px[i] = (i < 8) ? lo : hi;
  endtask

  function automatic logic [7:0] clamp8(input int v);
    return (v < 0) ? 8'd0 : (v > 255) ? 8'd255 : 8'(v);
  endfunction

  initial begin
    logic [23:0] grey [16];
    logic [23:0] white [16];
    logic [23:0] split [16];
    logic [23:0] px [16];
    logic [23:0] ca, cb;
    bit          fl;
    int          style, c0;

    fill(grey, 24'h808080, 24'h808080);
    fill(white, 24'hFFFFFF, 24'hFFFFFF);
    fill(split, 24'h000000, 24'hFFFFFF);

    rsrt        = 1'b1;
    bus.pix_rtr = 1'b0;
    bus.flip    = 1'b0;
    {bus.r, bus.g, bus.b} = '0;
    repeat (3) @(negedge sclk);
    check("rst_block", bus.block, 64'd0);
    check("rst_rts", 64'(bus.block_rts), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_rdy", 64'(bus.pix_rdy), 64'd1);
    rsrt = 1'b0;
    @(negedge sclk);

    // Directed tiles with random pix_rtr gaps.
    send_tile(grey, 1'b0, 1'b1, 1'b1, GreyBlk);   wait_pulse();
    send_tile(white, 1'b0, 1'b1, 1'b1, White0);   wait_pulse();
    send_tile(white, 1'b1, 1'b1, 1'b1, White1);   wait_pulse();
    send_tile(split, 1'b0, 1'b1, 1'b1, SplitBlk); wait_pulse();

    // Random tiles against the model.
    for (int n = 0; n < 6; n++) begin
      fl    = 1'($urandom);
      style = $urandom_range(0, 2);
      ca    = 24'($urandom);
      cb    = 24'($urandom);
      for (int i = 0; i < 16; i++) begin
        case (style)
          0: px[i] = 24'($urandom);
          1: px[i] = {clamp8(int'(ca[23:16]) + $urandom_range(0, 40) - 20),
                      clamp8(int'(ca[15:8])  + $urandom_range(0, 40) - 20),
                      clamp8(int'(ca[7:0])   + $urandom_range(0, 40) - 20)};
          default: px[i] = (sb_of(i, fl) == 0) ? ca : cb;
        endcase
      end
      send_tile(px, fl, 1'b1, 1'b1, model_block(px, fl));
      wait_pulse();
    end

    // Reset in the middle of processing; the partial block must vanish.
    send_tile(grey, 1'b0, 1'b1, 1'b0, 64'd0);
    c0 = cyc;
    while (cyc < c0 + ResetAt) @(negedge sclk);
    bus.pix_rtr = 1'b0;
    rsrt = 1'b1;
    #1;
    check("mid_rst_block", bus.block, 64'd0);
    check("mid_rst_rdy", 64'(bus.pix_rdy), 64'd1);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_rts", 64'(bus.block_rts), 64'd0);
    @(negedge sclk);
    @(negedge sclk);
    rsrt = 1'b0;
    @(negedge sclk);
    send_tile(grey, 1'b0, 1'b1, 1'b1, GreyBlk);   wait_pulse();

    // Back-to-back with pix_rtr held high.
    @(negedge sclk);
    send_tile(white, 1'b0, 1'b0, 1'b1, White0);
    send_tile(split, 1'b0, 1'b0, 1'b1, SplitBlk);
    wait_pulse();
    @(negedge sclk);
    check("b2b_spacing", 64'(pulse_last - pulse_prev), 64'(Period));

    repeat (5) @(negedge sclk);
    check("pending_blocks", 64'(sb_q.size()), 64'd0);
    check("pixels_accepted", 64'(mon_acc), 64'(drv_acc));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
